// File: rtl/bp_pkg.sv
// Shared types, widths and helpers for the branch predictor and its BTB.
// The table entry layout is built from the package widths below.
package bp_pkg;

    localparam int BP_ENTRIES = 64;
    localparam int BP_CNT_W   = 2;
    localparam int BP_TAG_W   = 8;
    localparam int BP_ADDR_W  = 32;

    typedef struct packed {
        logic                 valid;
        logic [BP_TAG_W-1:0]  tag;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_CNT_W-1:0]  cnt;
    } bp_entry_t;

    function automatic logic [BP_CNT_W-1:0] cnt_weak_nt(input int cnt_w);
        return BP_CNT_W'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic logic [BP_CNT_W-1:0] cnt_weak_t(input int cnt_w);
        return BP_CNT_W'(1 << (cnt_w - 1));
    endfunction

    function automatic logic [BP_CNT_W-1:0] cnt_strong_t(input int cnt_w);
        return BP_CNT_W'((1 << cnt_w) - 1);
    endfunction

    // Word-aligned PCs: the two LSBs never take part in index or tag.
    function automatic int bp_idx(input logic [BP_ADDR_W-1:0] pc, input int idx_w);
        return int'((pc >> 2) & ((32'd1 << idx_w) - 32'd1));
    endfunction

    function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [BP_ADDR_W-1:0] pc, input int idx_w);
        return BP_TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-value logic with priority load.
// Load wins over increment, increment over decrement; never wraps.
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_comb begin
        cnt_out = cnt_in;
        if (load) begin
            cnt_out = load_val;
        end else if (inc && (cnt_in != CNT_MAX)) begin
            cnt_out = cnt_in + CNT_W'(1);
        end else if (dec && (cnt_in != '0)) begin
            cnt_out = cnt_in - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor + BTB with combinational lookup and mispredict.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int CNT_W   = BP_CNT_W,
    parameter int TAG_W   = BP_TAG_W,
    parameter int ADDR_W  = BP_ADDR_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic              upd_is_jump,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t        tbl_q [ENTRIES];
    bp_entry_t        tbl_d [ENTRIES];
    bp_entry_t        rd_ent;
    bp_entry_t        up_ent;
    bp_entry_t        wr_ent;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             rd_hit;
    logic             up_hit;
    logic             up_wr;
    logic             sc_inc;
    logic             sc_dec;
    logic             sc_load;
    logic [CNT_W-1:0] sc_load_val;
    logic [CNT_W-1:0] sc_cnt;

    always_comb begin
        rd_idx      = IDX_W'(bp_idx(if_pc, IDX_W));
        rd_ent      = tbl_q[rd_idx];
        rd_hit      = rd_ent.valid && (rd_ent.tag == bp_tag(if_pc, IDX_W));
        pred_taken  = rd_hit && rd_ent.cnt[CNT_W-1];
        pred_target = pred_taken ? rd_ent.target : '0;
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = upd_taken ? upd_target : (upd_pc + ADDR_W'(4));
        end
    end

    // A miss allocates only on taken; a not-taken miss leaves any alias in place.
    always_comb begin
        up_idx      = IDX_W'(bp_idx(upd_pc, IDX_W));
        up_tag      = bp_tag(upd_pc, IDX_W);
        up_ent      = tbl_q[up_idx];
        up_hit      = up_ent.valid && (up_ent.tag == up_tag);
        up_wr       = enable && upd_valid && (up_hit || upd_taken);
        sc_load     = up_hit ? upd_is_jump : upd_taken;
        sc_load_val = (up_hit || upd_is_jump) ? cnt_strong_t(CNT_W) : cnt_weak_t(CNT_W);
        sc_inc      = up_hit && !upd_is_jump && upd_taken;
        sc_dec      = up_hit && !upd_is_jump && !upd_taken;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cnt_in   (up_ent.cnt),
        .inc      (sc_inc),
        .dec      (sc_dec),
        .load     (sc_load),
        .load_val (sc_load_val),
        .cnt_out  (sc_cnt)
    );

    always_comb begin
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = up_tag;
        wr_ent.target = (upd_taken || upd_is_jump) ? upd_target : up_ent.target;
        wr_ent.cnt    = sc_cnt;
        tbl_d         = tbl_q;
        if (up_wr) begin
            tbl_d[up_idx] = wr_ent;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: cnt_weak_nt(CNT_W)};
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (enable && upd_valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (enable && mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_branches    = 32'h0;
    assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (64 entries, 2-bit counters).
module tb_branch_predictor;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_is_jump;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .enable           (enable),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_is_jump      (upd_is_jump),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tg);
        if_pc = pc;
        push("pred_taken", {31'b0, exp_tk});
        push("pred_target", exp_tg);
        #1;
        pop_chk({31'b0, pred_taken});
        pop_chk(pred_target);
    endtask

    task automatic upd(input logic jmp, input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg,
                       input logic exp_mis, input logic [31:0] exp_red);
        upd_valid       = 1'b1;
        upd_is_jump     = jmp;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
        push("mispredict", {31'b0, exp_mis});
        push("redirect_pc", exp_red);
        #1;
        pop_chk({31'b0, mispredict});
        pop_chk(redirect_pc);
    endtask

    task automatic stats(input int br, input int mp);
        push("stat_branches", STATS ? 32'(br) : 32'h0);
        push("stat_mispredicts", STATS ? 32'(mp) : 32'h0);
        pop_chk(stat_branches);
        pop_chk(stat_mispredicts);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    initial begin
        arst_n          = 1'b0;
        enable          = 1'b1;
        if_pc           = 32'h40;
        upd_valid       = 1'b0;
        upd_is_jump     = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;

        #2;
        lookup(32'h40, 1'b0, 32'h0);
        stats(0, 0);
        push("mispredict_idle", 32'h0);
        pop_chk({31'b0, mispredict});
        #10 arst_n = 1'b1;
        tick();

        // Allocate, with the same-cycle lookup still seeing the old entry.
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40, 1'b0, 32'h0);
        tick();
        lookup(32'h40, 1'b1, 32'h80);

        upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h44);
        tick();
        lookup(32'h40, 1'b0, 32'h0);
        upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        // Counter must sit at 0: one taken gives 1 (still not-taken), a second gives 2.
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        lookup(32'h40, 1'b0, 32'h0);
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        lookup(32'h40, 1'b1, 32'h80);
        stats(6, 4);

        // Alias at the same index evicts the first branch.
        upd(1'b0, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        tick();
        lookup(32'h40, 1'b0, 32'h0);
        lookup(32'h140, 1'b1, 32'h200);

        upd(1'b1, 32'h1000, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h3000);
        tick();
        lookup(32'h1000, 1'b1, 32'h3000);
        upd(1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b1, 32'h1004);
        tick();
        lookup(32'h1000, 1'b1, 32'h3000);

        enable = 1'b0;
        upd(1'b0, 32'h2000, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
        tick();
        enable = 1'b1;
        lookup(32'h1000, 1'b1, 32'h3000);
        lookup(32'h2000, 1'b0, 32'h0);
        stats(9, 7);

        upd(1'b0, 32'h140, 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h240);
        tick();
        lookup(32'h140, 1'b1, 32'h240);
        upd(1'b0, 32'h140, 1'b1, 32'h240, 1'b1, 32'h240, 1'b0, 32'h0);
        tick();
        upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
        tick();
        stats(12, 9);

        // Reset lands while an allocating update is pending.
        upd(1'b0, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 32'h600);
        #1 arst_n = 1'b0;
        lookup(32'h140, 1'b0, 32'h0);
        stats(0, 0);
        tick();
        arst_n = 1'b1;
        lookup(32'h500, 1'b0, 32'h0);
        lookup(32'h1000, 1'b0, 32'h0);
        tick();
        stats(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
